// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
// Parity types, frame indices and legal oversampling ratios.
package uart_rx_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [3:0] START_IDX = 4'd0;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Index of the stop bit: start + data bits (+ parity)
  function automatic logic [3:0] stop_idx(
    input int   dw,
    input logic par_en
  );
    return 4'(dw + 1 + int'(par_en));
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Mid-bit triple sampler with majority vote.
// Captures two early samples and votes with the live line.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       en,
  input  logic [5:0] prescale,
  input  logic [4:0] edge_cnt,
  output logic       vote,
  output logic       vote_en,
  output logic       sampled_bit,
  output logic       sample_valid
);

  logic [4:0] mid;
  logic       s0;
  logic       s1;

  assign mid     = 5'(prescale >> 1);
  assign vote    = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
  assign vote_en = en && (edge_cnt == 5'(mid + 5'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vote_en;
      if (en && edge_cnt == 5'(mid - 5'd1))
        s0 <= rx_in;
      if (en && edge_cnt == mid)
        s1 <= rx_in;
      if (vote_en)
        sampled_bit <= vote;
    end
  end

endmodule

// File: rtl/uart_rx_sampler_deser.sv
// UART receive deserialiser: routes voted bits into the shift
// register and checks start, parity and stop framing.
module uart_rx_sampler_deser
  import uart_rx_pkg::*;
#(
  parameter int dataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 dat_samp_en,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic [5:0]           prescale,
  input  logic [4:0]           edge_cnt,
  input  logic [3:0]           bit_cnt,
  output logic                 sampled_bit,
  output logic                 sample_valid,
  output logic                 start_glitch,
  output logic                 par_err,
  output logic                 stp_err,
  output logic [dataWidth-1:0] p_data,
  output logic                 data_valid
);

  localparam logic [3:0] PAR_IDX   = 4'(dataWidth + 1);
  localparam logic [3:0] DATA_LAST = 4'(dataWidth);

  logic                 vote;
  logic                 vote_en;
  logic                 active;
  logic                 par_exp;
  logic [3:0]           last_idx;
  logic [dataWidth-1:0] shift;

  uart_rx_data_sampler u_sampler (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .en           (dat_samp_en),
    .prescale     (prescale),
    .edge_cnt     (edge_cnt),
    .vote         (vote),
    .vote_en      (vote_en),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  assign last_idx = stop_idx(dataWidth, par_en);
  assign par_exp  = (par_typ == PAR_ODD) ? ~^shift : ^shift;

  // active drops on a glitched start, at stop, or when disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      shift        <= '0;
      start_glitch <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (!dat_samp_en) begin
        active <= 1'b0;
      end else if (vote_en) begin
        if (bit_cnt == START_IDX) begin
          start_glitch <= vote;
          par_err      <= 1'b0;
          stp_err      <= 1'b0;
          shift        <= '0;
          active       <= ~vote;
        end else if (active) begin
          if (bit_cnt == last_idx) begin
            stp_err <= ~vote;
            active  <= 1'b0;
            if (vote && !par_err) begin
              p_data     <= shift;
              data_valid <= 1'b1;
            end
          end else if (par_en && bit_cnt == PAR_IDX) begin
            par_err <= (par_exp != vote);
          end else if (bit_cnt <= DATA_LAST) begin
            shift <= {vote, shift[dataWidth-1:1]};
          end
        end
      end
    end
  end

endmodule
